// File: rtl/windower_stride.sv
// windower_stride
//   Streaming 1-D sliding-window generator for the conv front end. Each
//   accepted beat carries one NO_CH-bit sample; a frame is 2**LOG2_IMG_SIZE
//   samples. Produces WINDOW-tap windows over the frame with PADDING zero
//   samples on each side, advancing STRIDE samples per window, and flags the
//   final window of each frame with last_out.
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   vld_in    input sample valid
//   rdy_in    block can accept a sample (beat = vld_in & rdy_in)
//   data_in   input sample
//   vld_out   window valid
//   rdy_out   downstream accepts window (beat = vld_out & rdy_out)
//   data_out  WINDOW taps, tap j at bits [j*NO_CH +: NO_CH]; tap 0 oldest
//   last_out  qualifies vld_out: final window of the current frame
module windower_stride #(
  parameter int NO_CH         = 16,
  parameter int LOG2_IMG_SIZE = 6,
  parameter int WINDOW        = 3,
  parameter int PADDING       = 1,
  parameter int STRIDE        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld_in,
  output logic                    rdy_in,
  input  logic [NO_CH-1:0]        data_in,
  output logic                    vld_out,
  input  logic                    rdy_out,
  output logic [WINDOW*NO_CH-1:0] data_out,
  output logic                    last_out
);

  localparam int N  = 1 << LOG2_IMG_SIZE;
  localparam int K  = (N + 2*PADDING - WINDOW) / STRIDE + 1;
  localparam int CW = LOG2_IMG_SIZE + 1;
  localparam int OW = $clog2(K + 1);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N - 1);
  localparam logic [CW-1:0] LAST_SHIFT  = CW'(N - 1 + PADDING);
  // Shift index whose completion first fills the window (P + c + 1 == W).
  localparam logic [CW-1:0] FIRST_WIN   = CW'(WINDOW - PADDING - 1);
  localparam logic [OW-1:0] K_LAST      = OW'(K - 1);
  localparam logic [PW-1:0] PH_LAST     = PW'(STRIDE - 1);

  if ((N + 2*PADDING - WINDOW) % STRIDE != 0) begin : g_bad_stride
    $error("windower_stride: (N + 2*PADDING - WINDOW) must be a multiple of STRIDE");
  end
  if (WINDOW < 1 || WINDOW > N || PADDING < 0 || PADDING >= WINDOW ||
      STRIDE < 1 || STRIDE > WINDOW) begin : g_bad_param
    $error("windower_stride: parameter out of range");
  end

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                    state;
  logic [CW-1:0]             in_cnt;   // shifts taken this frame, excluding implicit left pad
  logic [PW-1:0]             phase;    // completed-window index modulo STRIDE
  logic [OW-1:0]             out_cnt;
  logic [WINDOW*NO_CH-1:0]   sr_next;
  logic [NO_CH-1:0]          new_val;
  logic                      free, advance, win_done, emit, frame_end;

  assign free   = !vld_out | rdy_out;
  assign rdy_in = (state == RUN) & free & rst;

  always_comb begin
    advance   = (state == RUN) ? (vld_in & rdy_in) : free;
    new_val   = (state == RUN) ? data_in : '0;
    win_done  = advance & (in_cnt >= FIRST_WIN);
    emit      = win_done & (phase == '0);
    // In RUN with padding the count never reaches LAST_SHIFT, so this
    // fires on the last sample when P==0 and on the last zero shift otherwise.
    frame_end = advance & (in_cnt == LAST_SHIFT);
  end

  // The oldest tap is only ever shifted out, so only W-1 taps are stored;
  // the full window is the stored history plus the incoming value.
  if (WINDOW > 1) begin : g_hist
    logic [(WINDOW-1)*NO_CH-1:0] hist;
    assign sr_next = {new_val, hist};
    always_ff @(posedge clk) begin
      if (!rst) begin
        hist <= '0;
      end else if (advance) begin
        hist <= frame_end ? '0 : sr_next[WINDOW*NO_CH-1:NO_CH];
      end
    end
  end else begin : g_no_hist
    assign sr_next = new_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      in_cnt   <= '0;
      phase    <= '0;
      out_cnt  <= '0;
      vld_out  <= 1'b0;
      last_out <= 1'b0;
      data_out <= '0;
    end else begin
      if (advance) begin
        if (frame_end) begin
          state   <= RUN;
          in_cnt  <= '0;
          phase   <= '0;
          out_cnt <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
          if (state == RUN && in_cnt == LAST_SAMPLE) state <= FLUSH;
          if (win_done) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
          if (emit) out_cnt <= out_cnt + 1'b1;
        end
      end
      if (emit) begin
        vld_out  <= 1'b1;
        data_out <= sr_next;
        last_out <= (out_cnt == K_LAST);
      end else if (free) begin
        vld_out  <= 1'b0;
        last_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_windower_stride.sv
// Bench for windower_stride: three parameter sets run side by side. Expected
// windows are computed directly from the tap definition and queued when a
// frame is issued; a monitor pops and compares on every output beat.
module tb_windower_stride;
  localparam int N    = 64;
  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit done [NCFG];

  task automatic check(input int cfg, input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", cfg, name, act, exp, $time);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = (g == 1) ? 4 : 3;
    localparam int P = (g == 2) ? 0 : 1;
    localparam int S = (g == 1) ? 2 : 1;
    localparam int K = (N + 2*P - W) / S + 1;

    logic            rst, vld_in, rdy_in, vld_out, rdy_out, last_out;
    logic [15:0]     data_in;
    logic [W*16-1:0] data_out;
    int unsigned     x [2*N];
    logic [63:0]     exp_d [$];
    bit              exp_l [$];
    int              rmode = 0;   // 0: rdy_out=1, 1: pattern 1,0,0,1, 2: random

    windower_stride #(
      .NO_CH(16), .LOG2_IMG_SIZE(6), .WINDOW(W), .PADDING(P), .STRIDE(S)
    ) u_dut (
      .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in), .data_in(data_in),
      .vld_out(vld_out), .rdy_out(rdy_out), .data_out(data_out), .last_out(last_out)
    );

    // Window k of frame f: tap j = x[k*S+j-P], zero outside the frame.
    function automatic logic [63:0] ref_window(input int f, input int k);
      logic [63:0] w;
      int idx;
      w = '0;
      for (int j = 0; j < W; j++) begin
        idx = k*S + j - P;
        if (idx >= 0 && idx < N) w[j*16 +: 16] = 16'(x[f*N + idx]);
      end
      return w;
    endfunction

    // Shift c (0..N+P-1, zero shifts after N) completes a window to emit?
    function automatic bit emits(input int c);
      int pos;
      pos = P + c + 1;
      return (pos >= W) && (((pos - W) % S) == 0);
    endfunction

    function automatic bit win_last(input int c);
      return ((P + c + 1 - W) / S) == (K - 1);
    endfunction

    task automatic load_frames(input int nf, input int unsigned base, input bit rnd);
      for (int f = 0; f < nf; f++)
        for (int i = 0; i < N; i++)
          x[f*N + i] = rnd ? $urandom() : base + f*N + i;
      for (int f = 0; f < nf; f++)
        for (int k = 0; k < K; k++) begin
          exp_d.push_back(ref_window(f, k));
          exp_l.push_back(k == K - 1);
        end
    endtask

    // Cycle-exact expectations when rdy_out is held high: t counts negedges
    // since the previous accepted beat (shift index prev_c).
    task automatic strict_check(input int prev_c, input int t);
      bit fl, ev, exp_rdy;
      int c;
      fl = (prev_c == N - 1) && (P > 0);
      exp_rdy = !(fl && t < P);
      c = -1;
      if (t == 0 && prev_c >= 0) c = prev_c;
      else if (fl && t >= 1 && t <= P) c = N + t - 1;
      ev = (c >= 0) && emits(c);
      check(g, vld_out == ev, "vld_out_timing", vld_out, ev);
      if (ev) check(g, last_out == win_last(c), "last_out_timing", last_out, win_last(c));
      check(g, rdy_in == exp_rdy, "rdy_in_timing", rdy_in, exp_rdy);
    endtask

    // Called in posedge+1 context; returns in posedge+1 context.
    task automatic stream(input int nf, input int gap_at, input int gap_len,
                          input bit rnd_gaps, input bit strict, input int stop_after);
      int prev_c, i, idle;
      bit ok;
      prev_c = -1;
      for (int idx = 0; idx < nf*N; idx++) begin
        i = idx % N;
        idle = 0;
        if (idx == gap_at) idle = gap_len;
        else if (rnd_gaps && $urandom_range(0, 3) == 0) idle = $urandom_range(1, 2);
        vld_in  = 1'b0;
        data_in = 16'($urandom());
        ok = 1'b0;
        for (int t = 0; t < 2002; t++) begin
          if (t == idle) begin
            vld_in  = 1'b1;
            data_in = 16'(x[idx]);
          end
          @(negedge clk);
          if (strict) strict_check(prev_c, t);
          if (t >= idle && rdy_in) begin
            ok = 1'b1;
            break;
          end
          @(posedge clk);
          #1;
        end
        if (!ok) begin
          check(g, 1'b0, "rdy_in_timeout", 64'(idx), 64'(1));
          vld_in = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        prev_c = i;
        if (idx == stop_after) begin
          vld_in = 1'b0;
          return;
        end
      end
      vld_in = 1'b0;
      if (strict)
        for (int t = 0; t <= P; t++) begin
          @(negedge clk);
          strict_check(prev_c, t);
          @(posedge clk);
          #1;
        end
    endtask

    task automatic drain(input int next_mode);
      vld_in = 1'b0;
      for (int t = 0; t < 1000 && exp_d.size() != 0; t++) @(negedge clk);
      check(g, exp_d.size() == 0, "drain_windows_left", 64'(exp_d.size()), 64'(0));
      exp_d.delete();
      exp_l.delete();
      rmode = next_mode;
      repeat (4) @(posedge clk);
      #1;
    endtask

    task automatic reset_and_check();
      rst = 1'b0;
      vld_in = 1'b0;
      data_in = '0;
      @(posedge clk);
      @(negedge clk);
      check(g, vld_out == 1'b0, "reset_vld_out", vld_out, 0);
      check(g, last_out == 1'b0, "reset_last_out", last_out, 0);
      check(g, data_out == '0, "reset_data_out", 64'(data_out), 0);
      check(g, rdy_in == 1'b0, "reset_rdy_in", rdy_in, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
    endtask

    initial begin
      int ph;
      ph = 0;
      rdy_out = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (rmode)
          1:       rdy_out = (ph % 4 == 0) || (ph % 4 == 3);
          2:       rdy_out = ($urandom_range(0, 3) != 0);
          default: rdy_out = 1'b1;
        endcase
        ph++;
      end
    end

    initial begin
      logic [63:0] pd, ed;
      bit pl, pstall, el;
      pd = '0;
      pl = 1'b0;
      pstall = 1'b0;
      forever begin
        @(negedge clk);
        if (rst !== 1'b1) begin
          pstall = 1'b0;
        end else begin
          if (pstall) begin
            check(g, vld_out == 1'b1, "hold_vld_out", vld_out, 1);
            check(g, 64'(data_out) == pd, "hold_data_out", 64'(data_out), pd);
            check(g, last_out == pl, "hold_last_out", last_out, pl);
          end
          if (vld_out && !rdy_out)
            check(g, rdy_in == 1'b0, "rdy_in_under_backpressure", rdy_in, 0);
          if (vld_out && rdy_out) begin
            if (exp_d.size() == 0) begin
              check(g, 1'b0, "unexpected_window", 64'(data_out), 0);
            end else begin
              ed = exp_d.pop_front();
              el = exp_l.pop_front();
              check(g, 64'(data_out) == ed, "window_data", 64'(data_out), ed);
              check(g, last_out == el, "window_last", last_out, el);
            end
          end
          pstall = vld_out && !rdy_out;
          pd = 64'(data_out);
          pl = last_out;
        end
      end
    end

    if (g == 0) begin : g_plan_default
      initial begin
        reset_and_check();
        load_frames(1, 1024, 0); stream(1, -1, 0, 0, 1, -1); drain(0);  // T1
        load_frames(1, 1024, 0); stream(1, 20, 2, 0, 1, -1); drain(1);  // T3
        load_frames(1, 1024, 0); stream(1, -1, 0, 0, 0, -1); drain(0);  // T4
        load_frames(1, 1024, 0); stream(1, -1, 0, 0, 1, 30);            // T5
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(g, rdy_in == 1'b0, "rdy_in_in_reset", rdy_in, 0);
        check(g, exp_d.size() == K - 30, "abort_windows_seen", 64'(K - exp_d.size()), 64'(30));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        check(g, vld_out == 1'b0, "vld_out_after_abort", vld_out, 0);
        check(g, last_out == 1'b0, "last_out_after_abort", last_out, 0);
        @(posedge clk);
        #1;
        load_frames(1, 2048, 0); stream(1, -1, 0, 0, 1, -1); drain(2);
        for (int r = 0; r < 2; r++) begin
          load_frames(1, 0, 1); stream(1, -1, 0, 1, 0, -1); drain(2);
        end
        done[g] = 1'b1;
      end
    end else if (g == 1) begin : g_plan_stride2
      initial begin
        reset_and_check();
        load_frames(1, 1024, 0); stream(1, -1, 0, 0, 1, -1); drain(2);  // T2
        for (int r = 0; r < 2; r++) begin
          load_frames(1, 0, 1); stream(1, -1, 0, 1, 0, -1); drain(2);
        end
        done[g] = 1'b1;
      end
    end else begin : g_plan_nopad
      initial begin
        reset_and_check();
        load_frames(2, 1024, 0); stream(2, -1, 0, 0, 1, -1); drain(2);  // T6
        load_frames(2, 0, 1); stream(2, -1, 0, 1, 0, -1); drain(2);
        done[g] = 1'b1;
      end
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    if (!all_done) begin
      n_checks++;
      $display("FAIL global_timeout: got done=%0b%0b%0b, expected 111", done[2], done[1], done[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
